// File: rtl/cv32e40p_pkg.sv
// Shared types for the multiplier fault-tolerance monitor.
package cv32e40p_pkg;
  localparam int FT_MON_NSRC = 4;
  typedef enum logic [1:0] {IDLE, TRANSIENT, PERMANENT} ft_mon_state_e;
endpackage

// File: rtl/cv32e40p_ft_sat_cnt.sv
// Per-source saturating error counter with synchronous clear.
module cv32e40p_ft_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      value <= '0;
    else if (clr)                 value <= '0;
    else if (inc && value != '1)  value <= value + 1'b1;
  end
endmodule

// File: rtl/cv32e40p_mult_ft_monitor.sv
// Error monitor for the TMR multiplier voters: counters, sticky status, fault FSM, irq.
// Optional first-error timestamp built when CV32E40P_FT_MON_TIMESTAMP_EN is defined.
module cv32e40p_mult_ft_monitor
  import cv32e40p_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int PERM_THRESH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FT_MON_NSRC-1:0] error_detected_mult_i,
  input  logic                   clr_req_i,
  output logic                   clr_ack_o,
  input  logic [1:0]             cnt_sel_i,
  output logic [CNT_W-1:0]       cnt_o,
  output logic [FT_MON_NSRC-1:0] status_o,
  output logic                   perm_fault_o,
  output logic                   irq_o,
  output logic [31:0]            first_err_ts_o
);
  localparam int RUN_W = 8;

  ft_mon_state_e                         state_q;
  logic [RUN_W-1:0]                      run_q;
  logic                                  clr_fire;
  logic [FT_MON_NSRC-1:0]                flags;
  logic                                  any_err;
  logic                                  perm_entry;
  logic [FT_MON_NSRC-1:0][CNT_W-1:0]     cnt_q;

  // Clear wins over same-cycle flags: they are masked before anything sees them.
  assign clr_fire   = clr_req_i & ~clr_ack_o;
  assign flags      = clr_fire ? '0 : error_detected_mult_i;
  assign any_err    = |flags;
  assign perm_entry = (state_q == TRANSIENT) && any_err &&
                      (run_q == RUN_W'(PERM_THRESH - 1));

  for (genvar g = 0; g < FT_MON_NSRC; g++) begin : g_cnt
    cv32e40p_ft_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flags[g]),
      .clr   (clr_fire),
      .value (cnt_q[g])
    );
  end

  assign cnt_o = cnt_q[cnt_sel_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      run_q        <= '0;
      status_o     <= '0;
      perm_fault_o <= 1'b0;
      irq_o        <= 1'b0;
      clr_ack_o    <= 1'b0;
    end else if (clr_fire) begin
      state_q      <= IDLE;
      run_q        <= '0;
      status_o     <= '0;
      perm_fault_o <= 1'b0;
      irq_o        <= 1'b0;
      clr_ack_o    <= 1'b1;
    end else begin
      status_o <= status_o | flags;
      irq_o    <= (|(flags & ~status_o)) | perm_entry;
      if (!clr_req_i) clr_ack_o <= 1'b0;
      case (state_q)
        IDLE: if (any_err) begin
          state_q <= TRANSIENT;
          run_q   <= RUN_W'(1);
        end
        TRANSIENT: begin
          if (!any_err) begin
            state_q <= IDLE;
            run_q   <= '0;
          end else begin
            run_q <= run_q + 1'b1;
            if (perm_entry) begin
              state_q      <= PERMANENT;
              perm_fault_o <= 1'b1;
            end
          end
        end
        default: state_q <= PERMANENT;
      endcase
    end
  end

`ifdef CV32E40P_FT_MON_TIMESTAMP_EN
  logic [31:0] ts_q;

  // Free-running cycle count; only reset restarts it, clear does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q           <= '0;
      first_err_ts_o <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (clr_fire)                      first_err_ts_o <= '0;
      else if (status_o == '0 && any_err) first_err_ts_o <= ts_q;
    end
  end
`else
  assign first_err_ts_o = '0;
`endif
endmodule

// File: tb/tb_cv32e40p_mult_ft_monitor.sv
// Scoreboard bench for cv32e40p_mult_ft_monitor against a cycle-level reference model.
module tb_cv32e40p_mult_ft_monitor;
  localparam int CNT_W = 8;
  localparam int PT    = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       err = '0;
  logic             req = 1'b0;
  logic [1:0]       sel = '0;
  logic             ack;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       status;
  logic             perm, irq;
  logic [31:0]      ts;

  cv32e40p_mult_ft_monitor #(.CNT_W(CNT_W), .PERM_THRESH(PT)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .error_detected_mult_i (err),
    .clr_req_i             (req),
    .clr_ack_o             (ack),
    .cnt_sel_i             (sel),
    .cnt_o                 (cnt),
    .status_o              (status),
    .perm_fault_o          (perm),
    .irq_o                 (irq),
    .first_err_ts_o        (ts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic [3:0]       st;
    logic             perm, irq, ack;
    logic [31:0]      ts;
  } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0, irq_seen = 0;

  // reference model state
  int          m_cnt[4];
  logic [3:0]  m_st;
  int          m_run, m_state;
  bit          m_ack, m_irq;
  int unsigned m_ts, m_first;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_st = '0; m_run = 0; m_state = 0; m_ack = 0; m_irq = 0; m_ts = 0; m_first = 0;
    sb.delete();
  endtask

  task automatic step(input logic [3:0] f, input logic r);
    if (r && !m_ack) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_st = '0; m_run = 0; m_state = 0; m_ack = 1; m_irq = 0; m_first = 0;
    end else begin
      m_irq = (f & ~m_st) != 4'b0;
      if (m_st == 4'b0 && f != 4'b0) m_first = m_ts;
      m_st = m_st | f;
      for (int i = 0; i < 4; i++) if (f[i] && m_cnt[i] < CMAX) m_cnt[i]++;
      if (m_state == 0) begin
        if (f != 4'b0) begin m_state = 1; m_run = 1; end
      end else if (m_state == 1) begin
        if (f == 4'b0) begin m_state = 0; m_run = 0; end
        else begin
          m_run++;
          if (m_run >= PT) begin m_state = 2; m_irq = 1; end
        end
      end
      if (!r) m_ack = 0;
    end
    m_ts++;
  endtask

  task automatic cyc(input logic [3:0] f, input logic r, input logic [1:0] s);
    exp_t e, o;
    err = f; req = r; sel = s;
    step(f, r);
    e.cnt  = CNT_W'(m_cnt[s]);
    e.st   = m_st;
    e.perm = (m_state == 2);
    e.irq  = m_irq;
    e.ack  = m_ack;
`ifdef CV32E40P_FT_MON_TIMESTAMP_EN
    e.ts   = m_first;
`else
    e.ts   = 32'd0;
`endif
    sb.push_back(e);
    @(posedge clk); #1;
    o = sb.pop_front();
    irq_seen += int'(irq);
    chk("cnt_o",          32'(cnt),    32'(o.cnt));
    chk("status_o",       32'(status), 32'(o.st));
    chk("perm_fault_o",   32'(perm),   32'(o.perm));
    chk("irq_o",          32'(irq),    32'(o.irq));
    chk("clr_ack_o",      32'(ack),    32'(o.ack));
    chk("first_err_ts_o", ts,          o.ts);
  endtask

  // Async reset asserted mid-cycle: outputs must clear before any edge.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst cnt_o",   32'(cnt),    0);
    chk("rst status",  32'(status), 0);
    chk("rst perm",    32'(perm),   0);
    chk("rst irq",     32'(irq),    0);
    chk("rst ack",     32'(ack),    0);
    chk("rst ts",      ts,          0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    chk("por status", 32'(status), 0);
    chk("por ack",    32'(ack),    0);
    chk("por perm",   32'(perm),   0);
    @(negedge clk);
    rst = 1'b0;

    // timestamp capture at cycle 100, untouched by a later error at 200
    while (m_ts < 100) cyc(4'b0000, 1'b0, 2'd0);
    cyc(4'b0001, 1'b0, 2'd0);
    while (m_ts < 200) cyc(4'b0000, 1'b0, 2'd0);
    cyc(4'b0001, 1'b0, 2'd0);
`ifdef CV32E40P_FT_MON_TIMESTAMP_EN
    chk("ts held at 100", ts, 32'd100);
`else
    chk("ts disabled", ts, 32'd0);
`endif

    // clear handshake: ack rises, holds while req high, falls after req drops
    cyc(4'b0000, 1'b1, 2'd0);
    cyc(4'b0000, 1'b1, 2'd0);
    cyc(4'b0000, 1'b0, 2'd0);
    cyc(4'b0000, 1'b0, 2'd0);

    // three-cycle transient on the result voter
    irq_seen = 0;
    repeat (3) cyc(4'b0001, 1'b0, 2'd0);
    repeat (3) cyc(4'b0000, 1'b0, 2'd0);
    chk("transient cnt0",   32'(cnt),    3);
    chk("transient status", 32'(status), 32'b0001);
    chk("transient irqs",   32'(irq_seen), 1);
    chk("transient perm",   32'(perm),   0);

    // clear in the same cycle as a flag: flag discarded
    cyc(4'b0010, 1'b1, 2'd1);
    chk("clr+flag status", 32'(status), 0);
    chk("clr+flag irq",    32'(irq),    0);
    cyc(4'b0000, 1'b0, 2'd1);
    cyc(4'b0000, 1'b0, 2'd1);

    // permanent fault after PT consecutive error cycles
    irq_seen = 0;
    repeat (PT - 1) cyc(4'b0100, 1'b0, 2'd2);
    chk("perm before thresh", 32'(perm), 0);
    cyc(4'b0100, 1'b0, 2'd2);
    chk("perm at thresh", 32'(perm), 1);
    repeat (4) cyc(4'b0000, 1'b0, 2'd2);
    chk("perm sticky", 32'(perm), 1);
    chk("perm irqs",   32'(irq_seen), 2);

    // saturation of a counter without wrap
    cyc(4'b0000, 1'b1, 2'd3);
    cyc(4'b0000, 1'b0, 2'd3);
    repeat (CMAX + 40) cyc(4'b1000, 1'b0, 2'd3);
    chk("saturated cnt3", 32'(cnt), 32'(CMAX));

    // random mix of flags, clear requests and selects
    for (int i = 0; i < 400; i++) begin
      logic [3:0] f;
      f = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      cyc(f, ($urandom_range(0, 15) == 0) ? 1'b1 : req & ($urandom_range(0, 2) != 0),
          2'($urandom_range(0, 3)));
    end

    // async reset while permanent and ack both high, then req still high after release
    cyc(4'b0000, 1'b0, 2'd0);
    cyc(4'b0000, 1'b1, 2'd0);
    repeat (PT) cyc(4'b0100, 1'b1, 2'd2);
    chk("pre-rst perm", 32'(perm), 1);
    chk("pre-rst ack",  32'(ack),  1);
    pulse_reset();
    cyc(4'b0000, 1'b1, 2'd0);
    chk("post-rst new clear ack", 32'(ack), 1);
    cyc(4'b0000, 1'b0, 2'd0);
    cyc(4'b0001, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cv32e40p_mult_ft_monitor.md
CV32E40P_MULT_FT_MONITOR -- requirements
Module: cv32e40p_mult_ft_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of each per-source saturating error counter.
REQ-002 Parameter PERM_THRESH, default 16: consecutive error cycles that declare a permanent fault; legal range 2..255.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 error_detected_mult_i  input  4  voter mismatch flags from the TMR multiplier: [0] result, [1] multicycle, [2] mulh_active, [3] ready.
REQ-006 clr_req_i  input  1  clear request, four-phase level handshake.
REQ-007 clr_ack_o  output  1  clear acknowledge.
REQ-008 cnt_sel_i  input  2  selects which source counter appears on cnt_o.
REQ-009 cnt_o  output  CNT_W  selected counter value, combinational from cnt_sel_i and registered counters.
REQ-010 status_o  output  4  sticky per-source "error seen since clear" flags.
REQ-011 perm_fault_o  output  1  high while FSM is in PERMANENT.
REQ-012 irq_o  output  1  one-cycle event pulse.
REQ-013 first_err_ts_o  output  32  cycle timestamp of first error since clear.

Function
REQ-014 Each source counter SHALL increment by 1 in every cycle its flag is high, saturating at 2^CNT_W-1 (no wrap).
REQ-015 status_o[i] SHALL set in the cycle after error_detected_mult_i[i] is first sampled high and hold until clear.
REQ-016 FSM states IDLE, TRANSIENT, PERMANENT; run counter counts consecutive cycles with any flag high.
REQ-017 IDLE -> TRANSIENT when any flag high; run counter loads 1.
REQ-018 TRANSIENT: any flag high -> run counter +1; when it would reach PERM_THRESH -> PERMANENT; no flag high -> IDLE, run counter 0.
REQ-019 PERMANENT SHALL be left only by clear or reset; counters and status keep updating in PERMANENT.
REQ-020 irq_o SHALL pulse for exactly one cycle when any status_o bit transitions 0->1 or on entry to PERMANENT; both in the same cycle give one pulse.
REQ-021 Clear: on the first rising edge with clr_req_i high and clr_ack_o low, all counters, status_o, run counter and FSM (to IDLE) SHALL reset and clr_ack_o SHALL rise.
REQ-022 clr_ack_o SHALL stay high while clr_req_i is high and fall one cycle after clr_req_i falls; no new clear until ack is low.
REQ-023 Simultaneous clear and error flags: clear wins; flags in that cycle are discarded, no irq_o.
REQ-024 All outputs except cnt_o SHALL be registered; latency flag-in to counter/status/FSM update is 1 cycle.

Reset
REQ-025 While rst high: counters 0, status_o 0, run counter 0, FSM IDLE, perm_fault_o 0, irq_o 0, clr_ack_o 0, first_err_ts_o 0, timestamp counter 0.
REQ-026 Reset asserted mid-clear-handshake SHALL abort it; after release a still-high clr_req_i SHALL be treated as a new request.

Configuration
REQ-027 Macro CV32E40P_FT_MON_TIMESTAMP_EN defined: 32-bit free-running wrapping cycle counter; first_err_ts_o captures its value in the cycle the first flag since clear/reset is sampled, held until clear.
REQ-028 Macro undefined: no timestamp counter is built and first_err_ts_o SHALL be constant 0.

Structure
REQ-029 Shared package cv32e40p_pkg SHALL hold enum ft_mon_state_e {IDLE, TRANSIENT, PERMANENT} and constant FT_MON_NSRC = 4.
REQ-030 Per-source counters SHALL be four instances of sub-module cv32e40p_ft_sat_cnt (parameter CNT_W; inc, clr inputs; saturating value output).

Verification
REQ-031 Flag[0] high 3 cycles then low -> cnt_o(sel=0)=3, status_o=4'b0001, one irq_o pulse, FSM back to IDLE, perm_fault_o=0.
REQ-032 Flag[2] held 16 cycles, PERM_THRESH=16 -> perm_fault_o high 16th cycle after first flag, one further irq_o pulse; stays high after flag drops.
REQ-033 CNT_W=4, flag[3] held 40 cycles -> cnt_o(sel=3)=15, no wrap.
REQ-034 clr_req_i raised in same cycle as flag[1] -> next cycle all counters 0, status_o 0, clr_ack_o 1, no irq_o; ack falls 1 cycle after req falls.
REQ-035 Macro defined, reset released at cycle 0, flag[0] at cycle 100 -> first_err_ts_o=100; later flag at 200 leaves it 100; macro undefined -> 0.
REQ-036 rst pulsed asynchronously while perm_fault_o=1 and clr_ack_o=1 -> all outputs 0 immediately, FSM IDLE.
